// File: rtl/dac_loader.sv
// dac_loader: watches the gain/offset control codes and writes each changed
// channel to the external dual-channel 16-bit DAC as a 24-bit SPI mode-0 frame.
module dac_loader #(
    parameter int unsigned CLK_DIV = 5,
    parameter int unsigned CS_GAP  = 10
) (
    input  logic        clk_100M,
    input  logic        nrst,
    input  logic [15:0] dac_gain,
    input  logic [15:0] dac_offset,
    output logic        dac_sclk,
    output logic        dac_mosi,
    output logic        dac_cs_n,
    output logic        busy,
    output logic        done
);

    localparam int unsigned CODE_W  = 16;
    localparam int unsigned FRAME_W = 24;
    localparam int unsigned BIT_W   = 5;
    localparam int unsigned CNT_MAX = (CLK_DIV > CS_GAP) ? CLK_DIV : CS_GAP;
    localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_HOLD  = 2'd2;
    localparam logic [1:0] ST_GAP   = 2'd3;

    localparam logic [3:0] CMD_WRITE   = 4'b0011;
    localparam logic [3:0] ADDR_GAIN   = 4'h0;
    localparam logic [3:0] ADDR_OFFSET = 4'h1;

    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(CS_GAP - 1);
    localparam logic [BIT_W-1:0] TOP_BIT  = BIT_W'(FRAME_W - 1);

    logic [CODE_W-1:0]  samp_gain, samp_offset;
    logic [CODE_W-1:0]  shadow_gain, shadow_offset;
    logic [CODE_W-1:0]  shadow_gain_d, shadow_offset_d;
    logic               force_gain, force_offset;
    logic               force_gain_d, force_offset_d;
    logic               gain_pend_q, offset_pend_q;
    logic               gain_pend_c, offset_pend_c;

    logic [1:0]         state, state_d;
    logic [CNT_W-1:0]   cnt, cnt_d;
    logic [BIT_W-1:0]   bit_cnt, bit_cnt_d;
    logic [FRAME_W-2:0] shreg, shreg_d;
    logic [FRAME_W-1:0] launch_frame;
    logic               sclk_d, mosi_d, cs_n_d, busy_d, done_d;

    // Sample both codes every cycle so stability can be judged over two cycles
    always_ff @(posedge clk_100M or negedge nrst) begin
        if (!nrst) begin
            samp_gain   <= '0;
            samp_offset <= '0;
        end else begin
            samp_gain   <= dac_gain;
            samp_offset <= dac_offset;
        end
    end

    // A channel needs a write when its stable value differs from what was last sent
    always_comb begin
        gain_pend_c   = ((dac_gain == samp_gain) && (samp_gain != shadow_gain)) || force_gain;
        offset_pend_c = ((dac_offset == samp_offset) && (samp_offset != shadow_offset)) || force_offset;
    end

    // Register the pending decision; the FSM launches from these flags
    always_ff @(posedge clk_100M or negedge nrst) begin
        if (!nrst) begin
            gain_pend_q   <= 1'b0;
            offset_pend_q <= 1'b0;
        end else begin
            gain_pend_q   <= gain_pend_c;
            offset_pend_q <= offset_pend_c;
        end
    end

    // State, datapath and output registers
    always_ff @(posedge clk_100M or negedge nrst) begin
        if (!nrst) begin
            state         <= ST_IDLE;
            cnt           <= '0;
            bit_cnt       <= '0;
            shreg         <= '0;
            shadow_gain   <= '0;
            shadow_offset <= '0;
            force_gain    <= 1'b1;
            force_offset  <= 1'b1;
            dac_sclk      <= 1'b0;
            dac_mosi      <= 1'b0;
            dac_cs_n      <= 1'b1;
            busy          <= 1'b0;
            done          <= 1'b0;
        end else begin
            state         <= state_d;
            cnt           <= cnt_d;
            bit_cnt       <= bit_cnt_d;
            shreg         <= shreg_d;
            shadow_gain   <= shadow_gain_d;
            shadow_offset <= shadow_offset_d;
            force_gain    <= force_gain_d;
            force_offset  <= force_offset_d;
            dac_sclk      <= sclk_d;
            dac_mosi      <= mosi_d;
            dac_cs_n      <= cs_n_d;
            busy          <= busy_d;
            done          <= done_d;
        end
    end

    // Next-state and next-output logic: launch, shift, hold, inter-frame gap
    always_comb begin
        state_d         = state;
        cnt_d           = cnt;
        bit_cnt_d       = bit_cnt;
        shreg_d         = shreg;
        shadow_gain_d   = shadow_gain;
        shadow_offset_d = shadow_offset;
        force_gain_d    = force_gain;
        force_offset_d  = force_offset;
        sclk_d          = dac_sclk;
        mosi_d          = dac_mosi;
        cs_n_d          = dac_cs_n;
        busy_d          = busy;
        done_d          = 1'b0;
        launch_frame    = '0;

        case (state)
            ST_IDLE: begin
                if (gain_pend_q || offset_pend_q) begin
                    if (gain_pend_q) begin
                        launch_frame  = {CMD_WRITE, ADDR_GAIN, samp_gain};
                        shadow_gain_d = samp_gain;
                        force_gain_d  = 1'b0;
                    end else begin
                        launch_frame    = {CMD_WRITE, ADDR_OFFSET, samp_offset};
                        shadow_offset_d = samp_offset;
                        force_offset_d  = 1'b0;
                    end
                    shreg_d   = launch_frame[FRAME_W-2:0];
                    mosi_d    = launch_frame[FRAME_W-1];
                    sclk_d    = 1'b0;
                    cs_n_d    = 1'b0;
                    busy_d    = 1'b1;
                    cnt_d     = '0;
                    bit_cnt_d = TOP_BIT;
                    state_d   = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (cnt == DIV_LAST) begin
                    cnt_d = '0;
                    if (!dac_sclk) begin
                        sclk_d = 1'b1;
                    end else begin
                        sclk_d = 1'b0;
                        if (bit_cnt == '0) begin
                            state_d = ST_HOLD;
                        end else begin
                            bit_cnt_d = bit_cnt - BIT_W'(1);
                            mosi_d    = shreg[FRAME_W-2];
                            shreg_d   = {shreg[FRAME_W-3:0], 1'b0};
                        end
                    end
                end else begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end
            ST_HOLD: begin
                if (cnt == DIV_LAST) begin
                    cnt_d   = '0;
                    cs_n_d  = 1'b1;
                    done_d  = 1'b1;
                    mosi_d  = 1'b0;
                    state_d = ST_GAP;
                end else begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end
            ST_GAP: begin
                if (cnt == GAP_LAST) begin
                    cnt_d   = '0;
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_dac_loader.sv
// tb_dac_loader: directed and random stimulus for dac_loader, checked every
// cycle against a frame-level timing model plus decoded-frame expectations.
module tb_dac_loader;

    localparam int unsigned D      = 5;
    localparam int unsigned G      = 10;
    localparam int          LOW    = 49 * D;
    localparam int          PERIOD = 49 * D + G + 1;

    logic        clk_100M = 1'b0;
    logic        nrst = 1'b0;
    logic [15:0] dac_gain = 16'h0000;
    logic [15:0] dac_offset = 16'h0000;
    logic        dac_sclk, dac_mosi, dac_cs_n, busy, done;

    dac_loader #(.CLK_DIV(D), .CS_GAP(G)) dut (
        .clk_100M   (clk_100M),
        .nrst       (nrst),
        .dac_gain   (dac_gain),
        .dac_offset (dac_offset),
        .dac_sclk   (dac_sclk),
        .dac_mosi   (dac_mosi),
        .dac_cs_n   (dac_cs_n),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk_100M = ~clk_100M;

    int vec_cnt = 0;
    int err_cnt = 0;
    int fail_prints = 0;
    int tcyc = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            if (fail_prints < 40)
                $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
            fail_prints++;
        end
    endtask

    always @(posedge clk_100M) tcyc++;

    // Reference model: which frame is on the wire and since which edge
    int          m_rel = 0;
    int          m_L = 0;
    int          m_next = 0;
    bit          m_act = 1'b0;
    logic [23:0] m_word = '0;
    logic [15:0] m_sh [2] = '{16'h0, 16'h0};
    logic [15:0] m_prev [2] = '{16'h0, 16'h0};
    bit          m_f [2] = '{1'b1, 1'b1};
    bit          m_p [2] = '{1'b0, 1'b0};

    always @(posedge clk_100M or negedge nrst) begin : model
        logic [15:0] cur [2];
        bit          np [2];
        int          ch;
        if (!nrst) begin
            m_rel = 0; m_L = 0; m_next = 0; m_act = 1'b0;
            for (int i = 0; i < 2; i++) begin
                m_sh[i] = '0; m_prev[i] = '0; m_f[i] = 1'b1; m_p[i] = 1'b0;
            end
        end else begin
            m_rel++;
            cur[0] = dac_gain;
            cur[1] = dac_offset;
            ch = -1;
            if (m_rel >= m_next) begin
                if (m_p[0]) ch = 0;
                else if (m_p[1]) ch = 1;
            end
            for (int i = 0; i < 2; i++)
                np[i] = ((cur[i] == m_prev[i]) && (m_prev[i] != m_sh[i])) || m_f[i];
            if (ch >= 0) begin
                m_word = {4'b0011, 4'(ch), m_prev[ch]};
                m_L = m_rel;
                m_act = 1'b1;
                m_next = m_rel + PERIOD;
                m_sh[ch] = m_prev[ch];
                m_f[ch] = 1'b0;
            end
            for (int i = 0; i < 2; i++) begin
                m_prev[i] = cur[i];
                m_p[i] = np[i];
            end
        end
    end

    // Expected {cs_n, sclk, mosi, busy, done} from the offset into the current frame
    function automatic logic [4:0] exp_out();
        int off;
        logic cs, sc, mo, dn;
        if (!m_act) return 5'b10000;
        off = m_rel - m_L;
        if (off >= LOW + int'(G)) return 5'b10000;
        cs = (off < LOW) ? 1'b0 : 1'b1;
        sc = (off < 48 * D) && (((off / D) % 2) == 1);
        if (off < 48 * D)  mo = m_word[23 - off / (2 * D)];
        else if (off < LOW) mo = m_word[0];
        else               mo = 1'b0;
        dn = (off == LOW);
        return {cs, sc, mo, 1'b1, dn};
    endfunction

    always @(negedge clk_100M)
        check("outputs", {27'b0, dac_cs_n, dac_sclk, dac_mosi, busy, done}, {27'b0, exp_out()});

    // SPI decoder and chip-select timing monitor
    logic [23:0] mon_sh = '0;
    int          mon_bits = 0;
    logic [23:0] frames_q [$];
    int          fall_q [$];
    int          low_q [$];
    int          low_len = 0;
    int          done_cnt = 0;
    logic        cs_prev = 1'b1;

    always @(negedge dac_cs_n) mon_bits = 0;
    always @(posedge dac_sclk) if (dac_cs_n === 1'b0) begin
        mon_sh = {mon_sh[22:0], dac_mosi};
        mon_bits++;
    end
    always @(posedge dac_cs_n) if (mon_bits == 24) begin
        frames_q.push_back(mon_sh);
        mon_bits = 0;
    end
    always @(negedge clk_100M) begin
        if (dac_cs_n === 1'b0) begin
            if (cs_prev) begin
                fall_q.push_back(tcyc);
                low_len = 0;
            end
            low_len++;
        end else if (!cs_prev) begin
            low_q.push_back(low_len);
        end
        cs_prev = (dac_cs_n !== 1'b0);
        if (done === 1'b1) done_cnt++;
    end

    function automatic logic [31:0] fq(input int i);
        return (frames_q.size() > i) ? {8'h0, frames_q[i]} : 32'hxxxxxxxx;
    endfunction
    function automatic logic [31:0] lq(input int i);
        return (low_q.size() > i) ? 32'(low_q[i]) : 32'hxxxxxxxx;
    endfunction
    function automatic logic [31:0] fall_gap(input int i);
        return (fall_q.size() > i + 1) ? 32'(fall_q[i + 1] - fall_q[i]) : 32'hxxxxxxxx;
    endfunction

    task automatic clear_mon();
        frames_q.delete();
        fall_q.delete();
        low_q.delete();
        done_cnt = 0;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk_100M);
    endtask

    initial begin : stim
        int c;
        int found;
        logic [15:0] old;
        cycles(3);
        #2 nrst = 1'b1;

        // Power-up: both channels written, gain first
        cycles(700);
        check("init_count", 32'(frames_q.size()), 32'd2);
        check("init_frame0", fq(0), 32'h00300000);
        check("init_frame1", fq(1), 32'h00310000);
        check("init_low0", lq(0), 32'd245);
        check("init_low1", lq(1), 32'd245);
        check("init_period", fall_gap(0), 32'd256);
        check("init_done", 32'(done_cnt), 32'd2);

        // Single gain change, latency from change to chip-select fall
        clear_mon();
        dac_gain = 16'hA5C3;
        c = tcyc;
        cycles(400);
        check("gain_count", 32'(frames_q.size()), 32'd1);
        check("gain_frame", fq(0), 32'h0030A5C3);
        check("gain_latency", (fall_q.size() > 0) ? 32'(fall_q[0] - c) : 32'hxxxxxxxx, 32'd3);

        // Both change together: gain then offset
        clear_mon();
        dac_gain = 16'h1234;
        dac_offset = 16'hBEEF;
        cycles(700);
        check("both_count", 32'(frames_q.size()), 32'd2);
        check("both_frame0", fq(0), 32'h00301234);
        check("both_frame1", fq(1), 32'h0031BEEF);

        // Offset changes and reverts during a gain frame: nothing extra sent
        clear_mon();
        dac_gain = 16'h0F0F;
        cycles(50);
        dac_offset = 16'h0001;
        cycles(50);
        dac_offset = 16'hBEEF;
        cycles(600);
        check("revert_count", 32'(frames_q.size()), 32'd1);
        check("revert_frame", fq(0), 32'h00300F0F);

        // Offset changes for good during a gain frame: sent after the gap
        clear_mon();
        dac_gain = 16'h0F00;
        cycles(50);
        dac_offset = 16'h0002;
        cycles(700);
        check("late_count", 32'(frames_q.size()), 32'd2);
        check("late_frame0", fq(0), 32'h00300F00);
        check("late_frame1", fq(1), 32'h00310002);
        check("late_period", fall_gap(0), 32'd256);

        // Rewrite of the same value and a one-cycle glitch: no traffic
        clear_mon();
        dac_gain = 16'h0F00;
        dac_offset = 16'h7777;
        cycles(1);
        dac_offset = 16'h0002;
        for (int i = 0; i < 10; i++) begin
            cycles(1);
            check("quiet_busy", {31'b0, busy}, 32'd0);
        end
        cycles(20);
        check("quiet_count", 32'(frames_q.size()), 32'd0);

        // Reset at bit 10 of a gain frame
        clear_mon();
        dac_gain = 16'h5555;
        found = 0;
        for (int i = 0; i < 20 && found == 0; i++) begin
            cycles(1);
            if (dac_cs_n === 1'b0) found = 1;
        end
        check("abort_started", 32'(found), 32'd1);
        cycles(137);
        check("abort_sclk_high", {31'b0, dac_sclk}, 32'd1);
        #2 nrst = 1'b0;
        #1;
        check("abort_cs_n", {31'b0, dac_cs_n}, 32'd1);
        check("abort_sclk", {31'b0, dac_sclk}, 32'd0);
        check("abort_busy", {31'b0, busy}, 32'd0);
        cycles(3);
        #2 nrst = 1'b1;
        cycles(700);
        check("abort_count", 32'(frames_q.size()), 32'd2);
        check("abort_frame0", fq(0), 32'h00305555);
        check("abort_frame1", fq(1), 32'h00310002);

        // Random traffic against the model
        for (int it = 0; it < 40; it++) begin
            @(negedge clk_100M);
            case ($urandom_range(0, 9))
                0, 1, 2: dac_gain = 16'($urandom);
                3, 4:    dac_offset = 16'($urandom);
                5: begin
                    dac_gain = 16'($urandom);
                    dac_offset = 16'($urandom);
                end
                6: begin
                    old = dac_gain;
                    dac_gain = 16'($urandom);
                    cycles(1);
                    dac_gain = old;
                end
                7: begin
                    old = dac_offset;
                    dac_offset = 16'($urandom);
                    cycles(1);
                    dac_offset = old;
                end
                8: begin
                    #2 nrst = 1'b0;
                    cycles(2);
                    #2 nrst = 1'b1;
                end
                default: ;
            endcase
            cycles($urandom_range(1, 400));
        end
        cycles(700);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
